gf_mixcolumn: RTL

Iterative AES MixColumns / InvMixColumns engine for one 32-bit state column over GF(2^8) with reduction polynomial x^8+x^4+x^3+x+1 (0x1B). It sits directly downstream of the GF(2^8) multiply stage. It is that stage's consumer in the round datapath: it applies the fixed column matrix using shift-and-xor (xtime) arithmetic, with all four output rows evaluated in parallel. Columns arrive and leave through valid/ready handshakes, so it can be chained between round-key add and the next round stage.

---
 rtl/gf_mixcolumn.sv | 117 +++++++++++
 1 files changed

// File: rtl/gf_mixcolumn.sv
// Iterative AES MixColumns / InvMixColumns over GF(2^8) for one 32-bit column.
// Horner evaluation over coefficient bits, all four rows in parallel, one bit per cycle.
module gf_mixcolumn (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_col,
    input  logic        in_inv,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_col
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [3:0][7:0]  s_q, s_d;
    logic [3:0][7:0]  acc_q, acc_d;
    logic [3:0][7:0]  step;
    logic             inv_q, inv_d;
    logic [1:0]       k_q, k_d;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Bit k of row-0 coefficient at position idx; row i uses idx = (j - i) mod 4.
    function automatic logic coeff_bit(input logic inv, input logic [1:0] idx,
                                       input logic [1:0] k);
        logic [3:0] c;
        if (inv) begin
            case (idx)
                2'd0:    c = 4'hE;
                2'd1:    c = 4'hB;
                2'd2:    c = 4'hD;
                default: c = 4'h9;
            endcase
        end else begin
            case (idx)
                2'd0:    c = 4'h2;
                2'd1:    c = 4'h3;
                default: c = 4'h1;
            endcase
        end
        return c[k];
    endfunction

    always_comb begin
        step = '0;
        for (int i = 0; i < 4; i++) begin
            step[i] = xtime(acc_q[i]);
            for (int j = 0; j < 4; j++) begin
                if (coeff_bit(inv_q, 2'(j - i), k_q)) begin
                    step[i] = step[i] ^ s_q[j];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        acc_d     = acc_q;
        inv_d     = inv_q;
        k_d       = k_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    for (int i = 0; i < 4; i++) begin
                        s_d[i] = in_col[31-8*i -: 8];
                    end
                    inv_d   = in_inv;
                    acc_d   = '0;
                    k_d     = in_inv ? 2'd3 : 2'd1;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                acc_d = step;
                k_d   = k_q - 2'd1;
                if (k_q == 2'd0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            s_q     <= '0;
            acc_q   <= '0;
            inv_q   <= 1'b0;
            k_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            acc_q   <= acc_d;
            inv_q   <= inv_d;
            k_q     <= k_d;
        end
    end

    assign out_col = {acc_q[0], acc_q[1], acc_q[2], acc_q[3]};

endmodule
